// File: rtl/ps2_key_decoder_if.sv
// PS/2 key decoder bus: byte handshake toward ps2_keyboard, event stream
// toward the consumer and the live modifier flags.
// The master modport is the decoder side; the slave modport is the
// keyboard/consumer side.
interface ps2_key_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_nextdata_n;
    logic       key_valid;
    logic       key_ack;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_repeat;
    logic [7:0] key_ascii;
    logic       mod_shift;
    logic       mod_ctrl;
    logic       mod_caps;

    modport master (
        input  ps2_data, ps2_ready, key_ack,
        output ps2_nextdata_n, key_valid, key_code, key_ext, key_break,
               key_repeat, key_ascii, mod_shift, mod_ctrl, mod_caps
    );

    modport slave (
        output ps2_data, ps2_ready, key_ack,
        input  ps2_nextdata_n, key_valid, key_code, key_ext, key_break,
               key_repeat, key_ascii, mod_shift, mod_ctrl, mod_caps
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode decoder: pulls bytes from ps2_keyboard, strips the
// E0/F0 prefixes, swallows the Pause (E1) sequence, tracks modifiers and
// queues {code, ext, break, repeat, ascii} events in a small FIFO.
// Optional feature: define KEYDEC_REPEAT_EN to queue typematic repeat makes
// with key_repeat=1; when undefined, repeat makes are popped and dropped.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    ps2_key_decoder_if.master bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rpt;
        logic [7:0] ascii;
    } event_t;

    state_t             state;
    logic               nextdata_n_q;
    logic [2:0]         discard_cnt;
    logic               ext_flag;
    logic               brk_flag;
    logic [8:0]         held_key;
    logic               lshift, rshift, lctrl, rctrl, caps;

    event_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               fifo_full;
    logic               take_byte;
    logic               is_make;
    logic               is_repeat;
    logic               not_a_key;
    logic               key_byte;
    logic               push;
    logic               pop;
    event_t             new_event;
    event_t             head;

    // Set-2 make code to ASCII; letters honour the upper-case request.
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper);
        logic [4:0] idx;
        logic       is_letter;
        logic [7:0] result;
        idx       = 5'd0;
        is_letter = 1'b1;
        result    = 8'h00;
        case (code)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;
            8'h23: idx = 5'd3;   8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;
            8'h34: idx = 5'd6;   8'h33: idx = 5'd7;   8'h43: idx = 5'd8;
            8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;
            8'h4D: idx = 5'd15;  8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;
            8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;  8'h3C: idx = 5'd20;
            8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            result = (upper ? 8'h41 : 8'h61) + {3'b000, idx};
        end else begin
            case (code)
                8'h45: result = 8'h30;  8'h16: result = 8'h31;
                8'h1E: result = 8'h32;  8'h26: result = 8'h33;
                8'h25: result = 8'h34;  8'h2E: result = 8'h35;
                8'h36: result = 8'h36;  8'h3D: result = 8'h37;
                8'h3E: result = 8'h38;  8'h46: result = 8'h39;
                8'h29: result = 8'h20;
                8'h5A: result = 8'h0D;
                8'h66: result = 8'h08;
                default: result = 8'h00;
            endcase
        end
        return result;
    endfunction

    // Classify the byte on offer and build the event it would push.
    always_comb begin
        fifo_full = (count == CNT_W'(FIFO_DEPTH));
        take_byte = (state == IDLE) && bus.ps2_ready && !fifo_full;
        is_make   = !brk_flag;
        is_repeat = is_make && (held_key == {ext_flag, bus.ps2_data});
        not_a_key = (discard_cnt != 3'd0) ||
                    (bus.ps2_data inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hFC, 8'hFE, 8'hFF});
        key_byte  = take_byte && !not_a_key;

        new_event.code  = bus.ps2_data;
        new_event.ext   = ext_flag;
        new_event.brk   = brk_flag;
        new_event.ascii = (ext_flag || brk_flag) ? 8'h00
                        : ascii_of(bus.ps2_data, (lshift | rshift) ^ caps);
`ifdef KEYDEC_REPEAT_EN
        new_event.rpt = is_repeat;
        push          = key_byte;
`else
        new_event.rpt = 1'b0;
        push          = key_byte && !is_repeat;
`endif
        pop = bus.key_ack && (count != '0);
    end

    // Byte FSM plus prefix, discard, held-key and modifier tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            nextdata_n_q <= 1'b1;
            discard_cnt  <= 3'd0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            held_key     <= 9'd0;
            lshift       <= 1'b0;
            rshift       <= 1'b0;
            lctrl        <= 1'b0;
            rctrl        <= 1'b0;
            caps         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_byte) begin
                        state        <= POP;
                        nextdata_n_q <= 1'b0;
                        if (discard_cnt != 3'd0) begin
                            discard_cnt <= discard_cnt - 3'd1;
                        end else begin
                            case (bus.ps2_data)
                                8'hE0: ext_flag    <= 1'b1;
                                8'hF0: brk_flag    <= 1'b1;
                                8'hE1: discard_cnt <= 3'd7;
                                8'h00, 8'hAA, 8'hFC, 8'hFE, 8'hFF: begin
                                    ext_flag <= 1'b0;
                                    brk_flag <= 1'b0;
                                end
                                default: begin
                                    ext_flag <= 1'b0;
                                    brk_flag <= 1'b0;
                                    if (is_make) begin
                                        if (!is_repeat) held_key <= {ext_flag, bus.ps2_data};
                                    end else if (held_key == {ext_flag, bus.ps2_data}) begin
                                        held_key <= 9'd0;
                                    end
                                    if (!ext_flag && bus.ps2_data == 8'h12) lshift <= is_make;
                                    if (!ext_flag && bus.ps2_data == 8'h59) rshift <= is_make;
                                    if (bus.ps2_data == 8'h14) begin
                                        if (ext_flag) rctrl <= is_make;
                                        else          lctrl <= is_make;
                                    end
                                    if (bus.ps2_data == 8'h58 && is_make && !is_repeat) caps <= !caps;
                                end
                            endcase
                        end
                    end
                end
                POP: begin
                    state        <= GAP;
                    nextdata_n_q <= 1'b1;
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Event FIFO pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Event storage; contents are only visible through the gated head below.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_event;
    end

    assign head               = mem[rd_ptr];
    assign bus.key_valid      = (count != '0);
    assign bus.key_code       = bus.key_valid ? head.code  : 8'h00;
    assign bus.key_ext        = bus.key_valid ? head.ext   : 1'b0;
    assign bus.key_break      = bus.key_valid ? head.brk   : 1'b0;
    assign bus.key_repeat     = bus.key_valid ? head.rpt   : 1'b0;
    assign bus.key_ascii      = bus.key_valid ? head.ascii : 8'h00;
    assign bus.ps2_nextdata_n = nextdata_n_q;
    assign bus.mod_shift      = lshift | rshift;
    assign bus.mod_ctrl       = lctrl | rctrl;
    assign bus.mod_caps       = caps;

endmodule
